// File: rtl/neuron_alu_sequencer.sv
// Sequences a shared 32-bit combinational ALU through MULT/SRA/ADD steps to compute
// one two-input neuron y = ((x1*w1)>>>shift) + ((x2*w2)>>>shift) + b.
module neuron_alu_sequencer #(
    parameter int         DATA_W     = 32,
    parameter logic [3:0] ALUOP_ADD  = 4'b0100,
    parameter logic [3:0] ALUOP_MULT = 4'b0110,
    parameter logic [3:0] ALUOP_SRA  = 4'b0010,
    parameter logic [3:0] ALUOP_IDLE = 4'b1000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] w1,
    input  logic [DATA_W-1:0] w2,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shift,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovf,
    input  logic              alu_zero,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] y,
    output logic              ovf_flag,
    output logic              zero_flag
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL1 = 3'd1,
        SRA1 = 3'd2,
        MUL2 = 3'd3,
        SRA2 = 3'd4,
        ADD1 = 3'd5,
        ADD2 = 3'd6
    } state_t;

    state_t                   state;
    logic signed [DATA_W-1:0] x1_r;
    logic signed [DATA_W-1:0] x2_r;
    logic signed [DATA_W-1:0] w1_r;
    logic signed [DATA_W-1:0] w2_r;
    logic signed [DATA_W-1:0] b_r;
    logic        [4:0]        shift_r;
    logic signed [DATA_W-1:0] p1;
    logic signed [DATA_W-1:0] p2;
    logic signed [DATA_W-1:0] acc;
    logic                     sticky;

    logic [DATA_W-1:0] shift_ext;
    assign shift_ext = {{(DATA_W-5){1'b0}}, shift_r};

    // ALU inputs are a pure function of state and latched registers
    always_comb begin
        alu_op1    = '0;
        alu_op2    = '0;
        alu_opcode = ALUOP_IDLE;
        case (state)
            MUL1: begin alu_op1 = x1_r; alu_op2 = w1_r;      alu_opcode = ALUOP_MULT; end
            SRA1: begin alu_op1 = p1;   alu_op2 = shift_ext; alu_opcode = ALUOP_SRA;  end
            MUL2: begin alu_op1 = x2_r; alu_op2 = w2_r;      alu_opcode = ALUOP_MULT; end
            SRA2: begin alu_op1 = p2;   alu_op2 = shift_ext; alu_opcode = ALUOP_SRA;  end
            ADD1: begin alu_op1 = p1;   alu_op2 = p2;        alu_opcode = ALUOP_ADD;  end
            ADD2: begin alu_op1 = acc;  alu_op2 = b_r;       alu_opcode = ALUOP_ADD;  end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            x1_r      <= '0;
            x2_r      <= '0;
            w1_r      <= '0;
            w2_r      <= '0;
            b_r       <= '0;
            shift_r   <= '0;
            p1        <= '0;
            p2        <= '0;
            acc       <= '0;
            sticky    <= 1'b0;
            y         <= '0;
            ovf_flag  <= 1'b0;
            zero_flag <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x1_r    <= x1;
                        x2_r    <= x2;
                        w1_r    <= w1;
                        w2_r    <= w2;
                        b_r     <= b;
                        shift_r <= shift;
                        sticky  <= 1'b0;
                        busy    <= 1'b1;
                        state   <= MUL1;
                    end
                end
                MUL1: begin
                    p1     <= alu_result;
                    sticky <= sticky | alu_ovf;
                    state  <= SRA1;
                end
                SRA1: begin
                    p1    <= alu_result;
                    state <= MUL2;
                end
                MUL2: begin
                    p2     <= alu_result;
                    sticky <= sticky | alu_ovf;
                    state  <= SRA2;
                end
                SRA2: begin
                    p2    <= alu_result;
                    state <= ADD1;
                end
                ADD1: begin
                    acc    <= alu_result;
                    sticky <= sticky | alu_ovf;
                    state  <= ADD2;
                end
                ADD2: begin
                    y         <= alu_result;
                    ovf_flag  <= sticky | alu_ovf;
                    zero_flag <= alu_zero;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_alu_sequencer.sv
// Directed bench for neuron_alu_sequencer with a behavioural model of the shared ALU.
module tb_neuron_alu_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] x1 = '0, x2 = '0, w1 = '0, w2 = '0, b = '0;
    logic [4:0]  shift = '0;
    logic [31:0] alu_op1, alu_op2, alu_result;
    logic [3:0]  alu_opcode;
    logic        alu_ovf, alu_zero;
    logic        busy, done, ovf_flag, zero_flag;
    logic [31:0] y;

    int n_tests = 0;
    int n_fail  = 0;

    int          lat, busy_cnt;
    logic [3:0]  mul1_opc;
    logic [31:0] mul1_op1, mul1_op2;

    always #5 clk = ~clk;

    neuron_alu_sequencer dut (
        .clk(clk), .resetn(resetn), .start(start),
        .x1(x1), .x2(x2), .w1(w1), .w2(w2), .b(b), .shift(shift),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
        .busy(busy), .done(done), .y(y), .ovf_flag(ovf_flag), .zero_flag(zero_flag)
    );

    // ALU model: signed add, signed multiply (low word), arithmetic shift, AND otherwise
    logic signed [63:0] prod;
    always_comb begin
        prod       = $signed(alu_op1) * $signed(alu_op2);
        alu_result = alu_op1 & alu_op2;
        alu_ovf    = 1'b0;
        case (alu_opcode)
            4'b0100: begin
                alu_result = alu_op1 + alu_op2;
                alu_ovf    = (alu_op1[31] == alu_op2[31]) && (alu_result[31] != alu_op1[31]);
            end
            4'b0110: begin
                alu_result = prod[31:0];
                alu_ovf    = (prod != {{32{prod[31]}}, prod[31:0]});
            end
            4'b0010: alu_result = $signed(alu_op1) >>> alu_op2[4:0];
            default: ;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic set_ops(input logic [31:0] a1, input logic [31:0] c1, input logic [31:0] a2,
                           input logic [31:0] c2, input logic [31:0] bb, input logic [4:0] sh);
        x1 = a1; w1 = c1; x2 = a2; w2 = c2; b = bb; shift = sh;
    endtask

    // Pulses start for one edge, then waits (bounded) for done; called at a negedge
    task automatic run_op();
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        mul1_opc = alu_opcode;
        mul1_op1 = alu_op1;
        mul1_op2 = alu_op2;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_done();
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_flags", {30'd0, ovf_flag, zero_flag}, 32'd0);
        check("rst_opcode", {28'd0, alu_opcode}, 32'h8);
        resetn = 1'b1;
        @(negedge clk);

        // basic computation with latency and MUL1 drive
        set_ops(32'd3, 32'd4, 32'd5, 32'd6, 32'd10, 5'd0);
        run_op();
        check("s1_mul1_opc", {28'd0, mul1_opc}, 32'h6);
        check("s1_mul1_op1", mul1_op1, 32'd3);
        check("s1_mul1_op2", mul1_op2, 32'd4);
        check("s1_latency", lat, 32'd7);
        check("s1_busy_cycles", busy_cnt, 32'd6);
        check("s1_y", y, 32'd52);
        check("s1_flags", {30'd0, ovf_flag, zero_flag}, 32'd0);
        check("s1_busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("s1_done_pulse", {31'd0, done}, 32'd0);
        check("s1_y_hold", y, 32'd52);

        // negative product with shift
        set_ops(32'hFFFFFFF8, 32'd4, 32'd2, 32'd3, 32'd0, 5'd2);
        run_op();
        check("s2_latency", lat, 32'd7);
        check("s2_y", y, 32'hFFFFFFF9);
        check("s2_flags", {30'd0, ovf_flag, zero_flag}, 32'd0);
        @(negedge clk);

        // multiply overflow, then sticky cleared by a clean run
        set_ops(32'h00010000, 32'h00010000, 32'd0, 32'd0, 32'd0, 5'd0);
        run_op();
        check("s3_y", y, 32'd0);
        check("s3_flags", {30'd0, ovf_flag, zero_flag}, 32'd3);
        @(negedge clk);
        set_ops(32'd3, 32'd4, 32'd5, 32'd6, 32'd10, 5'd0);
        run_op();
        check("s3b_y", y, 32'd52);
        check("s3b_flags", {30'd0, ovf_flag, zero_flag}, 32'd0);
        @(negedge clk);

        // cancelling terms give zero
        set_ops(32'd5, 32'd2, 32'hFFFFFFFB, 32'd2, 32'd0, 5'd0);
        run_op();
        check("s5_y", y, 32'd0);
        check("s5_flags", {30'd0, ovf_flag, zero_flag}, 32'd1);
        @(negedge clk);

        // start held high; operands switched while busy; restart in done cycle
        set_ops(32'd3, 32'd4, 32'd5, 32'd6, 32'd10, 5'd0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        set_ops(32'hFFFFFFF8, 32'd4, 32'd2, 32'd3, 32'd0, 5'd2);
        wait_done();
        check("b2b_first_lat", lat, 32'd4);
        check("b2b_first_y", y, 32'd52);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_rise", {31'd0, busy}, 32'd1);
        wait_done();
        check("b2b_second_lat", lat, 32'd6);
        check("b2b_second_y", y, 32'hFFFFFFF9);
        @(negedge clk);

        // asynchronous abort mid-operation
        set_ops(32'd3, 32'd4, 32'd5, 32'd6, 32'd10, 5'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_y", y, 32'd0);
        check("abort_flags", {30'd0, ovf_flag, zero_flag}, 32'd0);
        check("abort_opcode", {28'd0, alu_opcode}, 32'h8);
        busy_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) busy_cnt++;
        end
        resetn = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) busy_cnt++;
        end
        check("abort_no_done", busy_cnt, 32'd0);
        run_op();
        check("post_abort_lat", lat, 32'd7);
        check("post_abort_y", y, 32'd52);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
